// File: rtl/ecg_capture_writer.sv
// ECG capture writer: decimates ADC samples, triggers on a rising crossing,
// and writes one display-width record into the waveform RAM.
module ecg_capture_writer #(
  parameter int                    ADDR_WIDTH  = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 'h801,
  parameter int                    DEPTH       = 640,
  parameter int                    DECIM       = 4,
  parameter logic [11:0]           TRIG_LEVEL  = 12'd2048,
  parameter int                    TIMEOUT     = 1024,
  parameter int                    HOLD_FRAMES = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  sample_valid,
  input  logic [11:0]           sample_data,
  input  logic                  frame_end,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  output logic                  buffer_ready,
  output logic                  auto_trig,
  output logic [1:0]            state
);

  localparam int DW = 8;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int IW = $clog2(DEPTH) + 1;
  localparam int FW = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_CAPT  = 2'd2,
    S_HOLD  = 2'd3
  } st_t;

  st_t                   r_state, w_nstate;
  logic [DW-1:0]         r_dcnt, w_ndcnt;
  logic [11:0]           r_prev, w_nprev;
  logic [TW-1:0]         r_tcnt, w_ntcnt;
  logic [IW-1:0]         r_idx, w_nidx;
  logic [FW-1:0]         r_fcnt, w_nfcnt;
  logic                  r_ready, w_nready;
  logic                  r_auto, w_nauto;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;

  logic                  w_kept;
  logic                  w_cross;
  logic                  w_we;
  logic [IW-1:0]         w_widx;

  assign w_kept  = sample_valid && (r_dcnt == DW'(DECIM - 1));
  assign w_cross = w_kept && (r_prev < TRIG_LEVEL)
                   && (sample_data >= TRIG_LEVEL);

  always_comb begin
    w_nstate = r_state;
    w_ndcnt  = r_dcnt;
    w_nprev  = r_prev;
    w_ntcnt  = r_tcnt;
    w_nidx   = r_idx;
    w_nfcnt  = r_fcnt;
    w_nready = r_ready;
    w_nauto  = r_auto;
    w_we     = 1'b0;
    w_widx   = r_idx;
    if (!enable || r_state == S_IDLE) begin
      // Leaving or sitting in IDLE abandons any partial record.
      w_ndcnt = '0;
      w_nprev = '0;
      w_ntcnt = '0;
      w_nidx  = '0;
      w_nfcnt = '0;
      if (!enable) begin
        w_nstate = S_IDLE;
        w_nready = 1'b0;
      end else begin
        w_nstate = S_ARMED;
      end
    end else begin
      if (sample_valid) begin
        w_ndcnt = w_kept ? '0 : r_dcnt + DW'(1);
      end
      if (w_kept) begin
        w_nprev = sample_data;
      end
      unique case (r_state)
        S_ARMED: begin
          if (w_kept) begin
            w_ntcnt = r_tcnt + TW'(1);
            if (w_cross || r_tcnt == TW'(TIMEOUT - 1)) begin
              w_we     = 1'b1;
              w_widx   = '0;
              w_nidx   = IW'(1);
              w_nauto  = !w_cross;
              w_nready = 1'b0;
              w_nstate = S_CAPT;
            end
          end
        end
        S_CAPT: begin
          if (w_kept) begin
            w_we   = 1'b1;
            w_widx = r_idx;
            w_nidx = r_idx + IW'(1);
            if (r_idx == IW'(DEPTH - 1)) begin
              w_nidx   = '0;
              w_nready = 1'b1;
              w_nstate = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (frame_end) begin
            if (r_fcnt == FW'(HOLD_FRAMES - 1)) begin
              w_nfcnt  = '0;
              w_ntcnt  = '0;
              w_nstate = S_ARMED;
            end else begin
              w_nfcnt = r_fcnt + FW'(1);
            end
          end
        end
        default: w_nstate = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_dcnt  <= '0;
      r_prev  <= '0;
      r_tcnt  <= '0;
      r_idx   <= '0;
      r_fcnt  <= '0;
      r_ready <= 1'b0;
      r_auto  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= BASE_ADDR;
      r_wdata <= '0;
    end else begin
      r_state <= w_nstate;
      r_dcnt  <= w_ndcnt;
      r_prev  <= w_nprev;
      r_tcnt  <= w_ntcnt;
      r_idx   <= w_nidx;
      r_fcnt  <= w_nfcnt;
      r_ready <= w_nready;
      r_auto  <= w_nauto;
      r_we    <= w_we;
      if (w_we) begin
        r_addr  <= BASE_ADDR + ADDR_WIDTH'(w_widx);
        r_wdata <= {20'b0, sample_data};
      end
    end
  end

  assign ram_we       = r_we;
  assign ram_addr     = r_addr;
  assign ram_wdata    = r_wdata;
  assign buffer_ready = r_ready;
  assign auto_trig    = r_auto;
  assign state        = r_state;

endmodule

// File: tb/tb_ecg_capture_writer.sv
// Scoreboard bench for ecg_capture_writer: DECIM=4 and DECIM=1 instances
// share stimulus; only the enabled one is expected to write.
module tb_ecg_capture_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en0, en1, vld, fe;
  logic [11:0] dat;

  logic        we0, rdy0, at0, we1, rdy1, at1;
  logic [11:0] addr0, addr1;
  logic [31:0] wd0, wd1;
  logic [1:0]  st0, st1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [11:0] a;
    logic [31:0] d;
    int          c;
  } wr_t;

  wr_t q0[$];
  wr_t q1[$];

  ecg_capture_writer #(.DECIM(4)) u_dut (
    .clock(clk), .reset(rst_n), .enable(en0),
    .sample_valid(vld), .sample_data(dat), .frame_end(fe),
    .ram_we(we0), .ram_addr(addr0), .ram_wdata(wd0),
    .buffer_ready(rdy0), .auto_trig(at0), .state(st0)
  );

  ecg_capture_writer #(.DECIM(1)) u_dut1 (
    .clock(clk), .reset(rst_n), .enable(en1),
    .sample_valid(vld), .sample_data(dat), .frame_end(fe),
    .ram_we(we1), .ram_addr(addr1), .ram_wdata(wd1),
    .buffer_ready(rdy1), .auto_trig(at1), .state(st1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input int idx, input logic [11:0] v);
    q0.push_back('{a: 12'(12'h801 + idx), d: {20'b0, v}, c: cyc + 1});
  endtask

  task automatic push1(input int idx, input logic [11:0] v);
    q1.push_back('{a: 12'(12'h801 + idx), d: {20'b0, v}, c: cyc + 1});
  endtask

  // Four valids of one value: exactly one of them is kept at DECIM=4.
  task automatic grp(input logic [11:0] v, input int idx);
    for (int j = 0; j < 4; j++) begin
      vld = 1'b1;
      dat = v;
      if (j == 3 && idx >= 0) push0(idx, v);
      step();
    end
    vld = 1'b0;
  endtask

  always @(negedge clk) begin
    if (we0) begin
      if (q0.size() == 0) begin
        chk("we0_spurious", {20'b0, addr0}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = q0.pop_front();
        chk("w0_addr", {20'b0, addr0}, {20'b0, e.a});
        chk("w0_data", wd0, e.d);
        chk("w0_cyc", cyc, e.c);
      end
    end
  end

  always @(negedge clk) begin
    if (we1) begin
      if (q1.size() == 0) begin
        chk("we1_spurious", {20'b0, addr1}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = q1.pop_front();
        chk("w1_addr", {20'b0, addr1}, {20'b0, e.a});
        chk("w1_data", wd1, e.d);
        chk("w1_cyc", cyc, e.c);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    en0 = 1'b1;
    en1 = 1'b0;
    vld = 1'b0;
    fe  = 1'b0;
    dat = '0;

    // Reset held while stimulus toggles
    for (int i = 0; i < 6; i++) begin
      vld = 1'b1;
      dat = 12'(i * 900);
      fe  = i[0];
      step();
    end
    chk("rst_we", {31'b0, we0}, 0);
    chk("rst_st", {30'b0, st0}, 0);
    chk("rst_rdy", {31'b0, rdy0}, 0);
    chk("rst_auto", {31'b0, at0}, 0);
    chk("rst_addr", {20'b0, addr0}, 32'h801);
    chk("rst_wd", wd0, 0);
    vld = 1'b0;
    fe  = 1'b0;
    en0 = 1'b0;
    rst_n = 1'b1;
    step();
    chk("post_rst_st", {30'b0, st0}, 0);

    // Triggered capture on a ramp
    en0 = 1'b1;
    step();
    chk("armed_st", {30'b0, st0}, 1);
    for (int n = 0; n <= 131 + 4 * 639; n++) begin
      vld = 1'b1;
      dat = 12'(16 * n);
      if (n >= 131 && (n - 131) % 4 == 0) push0((n - 131) / 4, 12'(16 * n));
      step();
    end
    vld = 1'b0;
    step();
    step();
    chk("rec_left", q0.size(), 0);
    chk("rec_rdy", {31'b0, rdy0}, 1);
    chk("rec_st", {30'b0, st0}, 3);
    chk("rec_auto", {31'b0, at0}, 0);

    // Hold: crossings without frame_end must not write
    for (int c = 0; c < 500; c++) begin
      grp(12'd0, -1);
      grp(12'd4095, -1);
    end
    chk("hold_st", {30'b0, st0}, 3);
    chk("hold_rdy", {31'b0, rdy0}, 1);
    fe = 1'b1;
    step();
    fe = 1'b0;
    chk("rearm_st", {30'b0, st0}, 1);
    chk("rearm_rdy", {31'b0, rdy0}, 1);
    grp(12'd0, -1);
    grp(12'd4095, 0);
    chk("retrig_st", {30'b0, st0}, 2);
    chk("retrig_rdy", {31'b0, rdy0}, 0);

    // Abort after idx 300; enable drops on the kept idx 301 sample
    for (int i = 1; i <= 300; i++) grp(12'(i), i);
    for (int j = 0; j < 4; j++) begin
      vld = 1'b1;
      dat = 12'd301;
      if (j == 3) en0 = 1'b0;
      step();
    end
    vld = 1'b0;
    chk("abort_st", {30'b0, st0}, 0);
    chk("abort_rdy", {31'b0, rdy0}, 0);
    grp(12'd0, -1);
    grp(12'd4095, -1);
    chk("abort_left", q0.size(), 0);

    // Re-enable: record restarts at the base address
    en0 = 1'b1;
    step();
    grp(12'd4095, 0);
    chk("reen_st", {30'b0, st0}, 2);
    en0 = 1'b0;
    step();
    step();

    // Auto-trigger on constant input
    en0 = 1'b1;
    step();
    for (int k = 1; k <= 4096; k++) begin
      vld = 1'b1;
      dat = 12'd100;
      if (k == 4096) push0(0, 12'd100);
      step();
    end
    vld = 1'b0;
    chk("auto_flag", {31'b0, at0}, 1);
    chk("auto_st", {30'b0, st0}, 2);
    step();
    chk("auto_left", q0.size(), 0);

    // Asynchronous reset while a capture write is on the bus
    for (int j = 0; j < 4; j++) begin
      vld = 1'b1;
      dat = 12'd100;
      step();
    end
    vld = 1'b0;
    chk("pre_rst_we", {31'b0, we0}, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_we", {31'b0, we0}, 0);
    chk("arst_st", {30'b0, st0}, 0);
    chk("arst_addr", {20'b0, addr0}, 32'h801);
    chk("arst_auto", {31'b0, at0}, 0);
    en0 = 1'b0;
    rst_n = 1'b1;
    step();

    // DECIM=1 back-to-back capture
    en1 = 1'b1;
    step();
    chk("d1_armed", {30'b0, st1}, 1);
    for (int t = 0; t < 10; t++) begin
      vld = 1'b1;
      dat = 12'd0;
      step();
    end
    for (int i = 0; i < 640; i++) begin
      logic [11:0] v;
      v = (i == 0) ? 12'd4095 : 12'(i * 5);
      vld = 1'b1;
      dat = v;
      push1(i, v);
      step();
    end
    vld = 1'b0;
    step();
    step();
    chk("d1_left", q1.size(), 0);
    chk("d1_st", {30'b0, st1}, 3);
    chk("d1_rdy", {31'b0, rdy1}, 1);
    chk("d1_auto", {31'b0, at1}, 0);
    chk("d0_idle", {30'b0, st0}, 0);

    chk("q0_end", q0.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ecg_capture_writer.md
Name: ecg_capture_writer

Overview:
- Writer side of the ECG sample RAM that the VGA waveform display reads.
- Takes a 12-bit ADC sample stream, decimates it, and waits for a rising-edge trigger so the displayed trace is stable.
- Writes one screen-width record of samples into RAM at the address window the display scans.
- Will not re-arm until the display has finished a programmable number of frames, which limits tearing.

Parameters:
- ADDR_WIDTH, 12: RAM address width.
- BASE_ADDR, 12'h801: address of sample index 0. This is the display's column-0 address.
- DEPTH, 640: samples per record, one per display column.
- DECIM, 4: keep one of every DECIM valid samples. Legal range 1..255.
- TRIG_LEVEL, 12'd2048: rising-crossing threshold.
- TIMEOUT, 1024: kept samples in ARMED before an auto-trigger.
- HOLD_FRAMES, 1: frame_end pulses required in HOLD before re-arm. Legal range 1..15.

Ports:
- clock, input, 1: system clock. All logic is on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- enable, input, 1: capture enable, level-sensitive.
- sample_valid, input, 1: single-cycle strobe for a new ADC sample.
- sample_data, input, 12: ADC sample, unsigned, valid when sample_valid=1.
- frame_end, input, 1: single-cycle end-of-frame pulse from the VGA timing generator, synchronous to clock.
- ram_we, output, 1: RAM write enable.
- ram_addr, output, ADDR_WIDTH: RAM write address.
- ram_wdata, output, 32: write data, {20'b0, sample}.
- buffer_ready, output, 1: a complete record is in RAM.
- auto_trig, output, 1: the last record was started by timeout, not by a level crossing.
- state, output, 2: IDLE=0, ARMED=1, CAPTURE=2, HOLD=3.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: state=IDLE, ram_we=0, ram_addr=BASE_ADDR, ram_wdata=0, buffer_ready=0, auto_trig=0.
  - Internal: all counters=0, prev_sample=0.
- Decimation:
  - dcnt counts sample_valid cycles from 0 to DECIM-1, then wraps.
  - A sample is "kept" when sample_valid=1 and dcnt==DECIM-1. DECIM=1 keeps every valid sample.
  - dcnt runs in ARMED, CAPTURE and HOLD. It is held at 0 in IDLE.
- prev_sample:
  - Updated with every kept sample in ARMED, CAPTURE and HOLD, so a crossing is detectable on the first kept sample after arming.
  - Cleared in IDLE.
- Crossing: a kept sample is a crossing when prev_sample < TRIG_LEVEL and sample_data >= TRIG_LEVEL.
- IDLE:
  - enable=1 moves to ARMED on the next cycle.
  - tcnt=0 on entry to ARMED.
- ARMED:
  - Each kept sample increments tcnt.
  - A kept crossing triggers: write the sample at index 0, clear auto_trig, go to CAPTURE with idx=1.
  - Else, a kept sample with tcnt==TIMEOUT-1 forces a trigger: same actions, but set auto_trig=1.
  - buffer_ready clears on the trigger cycle.
- CAPTURE:
  - Each kept sample is written at BASE_ADDR+idx, then idx increments.
  - The write of idx==DEPTH-1 moves to HOLD and sets buffer_ready=1 in the same cycle.
  - The last address is 12'hA80 with defaults. Addresses never wrap past BASE_ADDR+DEPTH-1.
- HOLD:
  - No writes.
  - fcnt counts frame_end pulses. When fcnt reaches HOLD_FRAMES, go to ARMED next cycle, reset fcnt and tcnt, and keep buffer_ready=1.
  - A kept sample in the same cycle as the final frame_end updates prev_sample only. It is not trigger-evaluated.
- Write timing:
  - ram_we, ram_addr and ram_wdata are registered together. They assert exactly one cycle after the kept sample's sample_valid cycle, for exactly one cycle.
  - ram_we=0 otherwise. ram_addr and ram_wdata hold their last values while ram_we=0.
- enable=0 in any state:
  - Next cycle: state=IDLE, buffer_ready=0.
  - A write already registered from the previous cycle completes. No further writes.
  - A partial record is abandoned, and the next capture restarts at idx 0.
- Asynchronous reset mid-CAPTURE: ram_we drops immediately, all state as at reset.
- Simultaneous enable=0 and trigger: enable wins, no write is issued.
- sample_valid on consecutive cycles must be supported, i.e. a kept sample every cycle when DECIM=1.

Test Plan:
- Reset checks: hold reset=0 while applying stimulus, then release. Required: ram_we=0, state=0, buffer_ready=0, ram_addr=12'h801.
- Triggered capture: DECIM=4, enable=1, ramp sample_data 0,16,32,... one valid per cycle. Required:
  - First write at 12'h801 holds the first kept value >=2048.
  - 640 writes land at consecutive addresses through 12'hA80, each 4 samples apart, each one cycle after its strobe.
  - Then buffer_ready=1, state=3, auto_trig=0.
- Auto-trigger: constant input 100. Required: trigger on kept sample 1024 (valid #4096), auto_trig=1, wdata=32'd100 at 12'h801.
- Hold and re-arm: after a record completes, feed 500 crossings with no frame_end. Required: zero writes. One frame_end pulse, then state=1 next cycle; the next crossing writes at 12'h801.
- Abort: deassert enable after idx 300 is written. Required: no writes from the following cycle, state=0, buffer_ready=0. Re-enable: the next record starts at 12'h801.
- DECIM=1 back-to-back: valid every cycle with a step 0 to 4095. Required: write at 12'h801 =4095 one cycle after the step, followed by 639 consecutive-cycle writes.
